// File: rtl/ledpanel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ledpanel_pkg
//  Description : Shared types and constants for the LED-panel write arbiter:
//                arbiter state encoding, requester identifiers, pixel
//                address width, RGB565 width, video-memory byte-lane mask
//                and the position of the bank-select bit in ctrl_addr.
//  Revision    : 1.0 - initial release
// ============================================================================
package ledpanel_pkg;

  // Pixel address is {y[5:0], x[5:0]} for the 64x64 panel.
  localparam int PIX_AW = 12;

  // Pixel payload width (RGB565).
  localparam int RGB565_W = 16;

  // Only the low three byte lanes of the 24-bit memory word carry pixel data.
  localparam logic [3:0] CTRL_WR_MASK = 4'b0111;

  // ctrl_addr bit that selects the frame-buffer bank.
  localparam int BANK_BIT = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage
`default_nettype wire

// File: rtl/ledpanel_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ledpanel_rr_pick
//  Description : Two-way round-robin pick, purely combinational.
//                When both requesters are valid, the one that was NOT granted
//                last wins; otherwise the single valid requester wins.
//                With nothing valid the output is SRC_A and is ignored.
//  Ports       : a_valid, b_valid  - request lines
//                last_grant        - requester served by the previous grant
//                winner            - selected requester
//  Revision    : 1.0 - initial release
// ============================================================================
module ledpanel_rr_pick
  import ledpanel_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  src_t last_grant,
  output src_t winner
);

  always_comb begin
    winner = SRC_A;
    if (a_valid && b_valid) begin
      winner = (last_grant == SRC_A) ? SRC_B : SRC_A;
    end else if (b_valid) begin
      winner = SRC_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ledpanel_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ledpanel_write_arbiter
//  Description : Arbitrates two pixel streams (A: network, B: pattern gen)
//                onto a double-buffered video-memory write port. Writes go to
//                the back bank (!disp_bank). A frame_end beat arms a bank
//                swap that is executed on the next vblank; all beats stall
//                while the swap is pending.
//  Ports       : ctrl_clk, ctrl_resetn (sync, active-low)
//                a_* / b_*     - requester beat interfaces (valid/ready)
//                vblank        - display frame boundary pulse
//                ctrl_en/wr/addr/wdat - registered memory write port
//                disp_bank     - bank currently displayed
//                swap_pending  - finished back-bank frame awaiting vblank
//  Revision    : 1.0 - initial release
// ============================================================================
module ledpanel_write_arbiter #(
  parameter int BURST_MAX = 64,
  parameter int PIX_AW    = 12
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_resetn,

  input  logic              a_valid,
  input  logic              a_last,
  input  logic              a_frame_end,
  input  logic [PIX_AW-1:0] a_addr,
  input  logic [15:0]       a_data,
  output logic              a_ready,

  input  logic              b_valid,
  input  logic              b_last,
  input  logic              b_frame_end,
  input  logic [PIX_AW-1:0] b_addr,
  input  logic [15:0]       b_data,
  output logic              b_ready,

  input  logic              vblank,

  output logic              ctrl_en,
  output logic [3:0]        ctrl_wr,
  output logic [15:0]       ctrl_addr,
  output logic [23:0]       ctrl_wdat,
  output logic              disp_bank,
  output logic              swap_pending
);

  import ledpanel_pkg::*;

  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  src_t                r_last_grant;
  src_t                w_last_grant_nxt;
  src_t                w_winner;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    w_beat_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;

  logic                r_disp_bank;
  logic                r_swap_pending;
  logic                r_ctrl_en;
  logic [3:0]          r_ctrl_wr;
  logic [15:0]         r_ctrl_addr;
  logic [23:0]         r_ctrl_wdat;

  logic                w_sel_a;
  logic                w_sel_b;
  logic                w_ready_ok;
  logic                w_xfer;
  logic                w_limit;
  logic                w_x_last;
  logic                w_x_fe;
  logic [PIX_AW-1:0]   w_x_addr;
  logic [RGB565_W-1:0] w_x_data;
  logic [15:0]         w_wr_addr;

  ledpanel_rr_pick u_rr_pick (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner)
  );

  // Ready is gated by the reset input so that no beat is accepted in a
  // cycle whose closing edge resets the block.
  assign w_sel_a    = (r_state == ST_GRANT_A);
  assign w_sel_b    = (r_state == ST_GRANT_B);
  assign w_ready_ok = ctrl_resetn && !r_swap_pending;
  assign a_ready    = w_sel_a && w_ready_ok;
  assign b_ready    = w_sel_b && w_ready_ok;
  assign w_xfer     = (a_valid && a_ready) || (b_valid && b_ready);

  assign w_x_last   = w_sel_a ? a_last      : b_last;
  assign w_x_fe     = w_sel_a ? a_frame_end : b_frame_end;
  assign w_x_addr   = w_sel_a ? a_addr      : b_addr;
  assign w_x_data   = w_sel_a ? a_data      : b_data;

  assign w_cnt_inc  = r_beat_cnt + CNT_W'(1);
  assign w_limit    = (w_cnt_inc == CNT_W'(BURST_MAX));

  // Back-bank address: pixel address in the low bits, inverted display bank
  // in the bank-select bit, upper bits zero.
  always_comb begin
    w_wr_addr                = '0;
    w_wr_addr[PIX_AW-1:0]    = w_x_addr;
    w_wr_addr[BANK_BIT]      = ~r_disp_bank;
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (a_valid || b_valid) begin
          w_state_nxt = (w_winner == SRC_A) ? ST_GRANT_A : ST_GRANT_B;
        end
      end
      ST_GRANT_A, ST_GRANT_B: begin
        // Only a transferred beat can end the grant; an idle requester
        // keeps ownership until it delivers a last or limit beat.
        if (w_xfer) begin
          if (w_x_last || w_limit) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = w_sel_a ? SRC_A : SRC_B;
            w_beat_cnt_nxt   = '0;
          end else begin
            w_beat_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_resetn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= SRC_B;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Bank swap. A swap uses the pending flag from before this edge, so a
  // frame_end arriving together with vblank waits for the next vblank.
  // Beats never transfer while pending, so the two branches cannot collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_resetn) begin
      r_disp_bank    <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (vblank && r_swap_pending) begin
      r_disp_bank    <= ~r_disp_bank;
      r_swap_pending <= 1'b0;
    end else if (w_xfer && w_x_fe) begin
      r_swap_pending <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port; address/data hold between writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_resetn) begin
      r_ctrl_en   <= 1'b0;
      r_ctrl_wr   <= 4'b0000;
      r_ctrl_addr <= '0;
      r_ctrl_wdat <= '0;
    end else begin
      r_ctrl_en <= w_xfer;
      r_ctrl_wr <= w_xfer ? CTRL_WR_MASK : 4'b0000;
      if (w_xfer) begin
        r_ctrl_addr <= w_wr_addr;
        r_ctrl_wdat <= {8'h00, w_x_data};
      end
    end
  end

  assign ctrl_en      = r_ctrl_en;
  assign ctrl_wr      = r_ctrl_wr;
  assign ctrl_addr    = r_ctrl_addr;
  assign ctrl_wdat    = r_ctrl_wdat;
  assign disp_bank    = r_disp_bank;
  assign swap_pending = r_swap_pending;

endmodule
`default_nettype wire

// File: tb/tb_ledpanel_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ledpanel_write_arbiter
//  Description : Self-checking bench for ledpanel_write_arbiter (BURST_MAX=4).
//                A cycle-level reference model predicts ready, bank state and
//                the memory writes; writes go into a scoreboard queue that a
//                separate monitor drains whenever ctrl_en is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ledpanel_write_arbiter;

  localparam int BURST_MAX = 4;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_resetn = 1'b0;
  logic        a_valid = 0, a_last = 0, a_frame_end = 0;
  logic [11:0] a_addr = '0;
  logic [15:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 0, b_last = 0, b_frame_end = 0;
  logic [11:0] b_addr = '0;
  logic [15:0] b_data = '0;
  logic        b_ready;
  logic        vblank = 0;
  logic        ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        disp_bank;
  logic        swap_pending;

  always #5 ctrl_clk = ~ctrl_clk;

  ledpanel_write_arbiter #(.BURST_MAX(BURST_MAX), .PIX_AW(12)) dut (
    .ctrl_clk     (ctrl_clk),
    .ctrl_resetn  (ctrl_resetn),
    .a_valid      (a_valid),
    .a_last       (a_last),
    .a_frame_end  (a_frame_end),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_last       (b_last),
    .b_frame_end  (b_frame_end),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .vblank       (vblank),
    .ctrl_en      (ctrl_en),
    .ctrl_wr      (ctrl_wr),
    .ctrl_addr    (ctrl_addr),
    .ctrl_wdat    (ctrl_wdat),
    .disp_bank    (disp_bank),
    .swap_pending (swap_pending)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge ctrl_clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [23:0] wdat;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: owner 0 = nobody (arbitrating), 1 = A, 2 = B.
  int owner      = 0;
  int last_owner = 2;
  int beats      = 0;
  bit bank       = 0;
  bit pend       = 0;
  bit just_reset = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, ctrl_en must match whether a write is due now.
  initial begin
    wr_t e;
    bit  due;
    forever begin
      @(posedge ctrl_clk);
      #2;
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("ctrl_en", ctrl_en, due);
      if (due) begin
        e = exp_q.pop_front();
        if (ctrl_en) begin
          chk("ctrl_addr", ctrl_addr, e.addr);
          chk("ctrl_wdat", ctrl_wdat, e.wdat);
          chk("ctrl_wr",   ctrl_wr,   4'b0111);
        end
      end else if (!ctrl_en) begin
        chk("ctrl_wr_idle", ctrl_wr, 4'b0000);
      end
    end
  end

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic tick(output bit xa, output bit xb);
    bit ra, rb, xl, xfe, swap;
    logic [11:0] xaddr;
    logic [15:0] xdata;
    int n_owner, n_last, n_beats;
    bit n_bank, n_pend;
    #1;
    chk("disp_bank",    disp_bank,    bank);
    chk("swap_pending", swap_pending, pend);
    if (just_reset) begin
      chk("rst_ctrl_addr", ctrl_addr, 16'h0);
      chk("rst_ctrl_wdat", ctrl_wdat, 24'h0);
    end
    ra = ctrl_resetn && (owner == 1) && !pend;
    rb = ctrl_resetn && (owner == 2) && !pend;
    chk("a_ready", a_ready, ra);
    chk("b_ready", b_ready, rb);
    xa = ra && a_valid;
    xb = rb && b_valid;
    n_owner = owner; n_last = last_owner; n_beats = beats;
    n_bank = bank;   n_pend = pend;
    if (!ctrl_resetn) begin
      n_owner = 0; n_last = 2; n_beats = 0; n_bank = 0; n_pend = 0;
    end else begin
      swap = vblank && pend;
      if (owner == 0) begin
        if (a_valid && (!b_valid || last_owner == 2)) n_owner = 1;
        else if (b_valid)                             n_owner = 2;
      end else if (xa || xb) begin
        xl    = xa ? a_last      : b_last;
        xfe   = xa ? a_frame_end : b_frame_end;
        xaddr = xa ? a_addr      : b_addr;
        xdata = xa ? a_data      : b_data;
        exp_q.push_back('{due: cyc + 1,
                          addr: {3'b000, ~bank, xaddr},
                          wdat: {8'h00, xdata}});
        if (xfe) n_pend = 1;
        if (xl || (beats + 1 == BURST_MAX)) begin
          n_last = owner; n_owner = 0; n_beats = 0;
        end else begin
          n_beats = beats + 1;
        end
      end
      if (swap) begin
        n_bank = !bank;
        n_pend = 0;
      end
    end
    @(posedge ctrl_clk);
    owner = n_owner; last_owner = n_last; beats = n_beats;
    bank = n_bank;   pend = n_pend;
    just_reset = !ctrl_resetn;
    @(negedge ctrl_clk);
  endtask

  task automatic set_a(input bit v, input bit l, input bit fe, input logic [11:0] ad, input logic [15:0] d);
    a_valid = v; a_last = l; a_frame_end = fe; a_addr = ad; a_data = d;
  endtask

  task automatic set_b(input bit v, input bit l, input bit fe, input logic [11:0] ad, input logic [15:0] d);
    b_valid = v; b_last = l; b_frame_end = fe; b_addr = ad; b_data = d;
  endtask

  // Bring the model (and DUT) back to the arbitration state with no swap.
  task automatic drain();
    bit xa, xb;
    int n = 0;
    while ((owner != 0 || pend) && n < 20) begin
      set_a(1, 1, 0, 12'($urandom), 16'($urandom));
      set_b(1, 1, 0, 12'($urandom), 16'($urandom));
      vblank = 1;
      tick(xa, xb);
      n++;
    end
    chk("drain_timeout", (owner != 0 || pend), 0);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    vblank = 0;
  endtask

  // Present one A beat until it is accepted (bounded).
  task automatic a_beat(input bit l, input bit fe, input logic [11:0] ad, input logic [15:0] d,
                        input bit vb_every);
    bit xa, xb;
    int n = 0;
    xa = 0;
    while (!xa && n < 20) begin
      set_a(1, l, fe, ad, d);
      vblank = vb_every;
      tick(xa, xb);
      n++;
    end
    chk("a_beat_timeout", xa, 1);
    set_a(0, 0, 0, 0, 0);
    vblank = 0;
  endtask

  initial begin
    bit xa, xb;
    int n;

    // Reset held for a few cycles.
    ctrl_resetn = 0;
    @(negedge ctrl_clk);
    for (int i = 0; i < 3; i++) tick(xa, xb);
    ctrl_resetn = 1;

    // Both requesters always valid, single-beat bursts: A, B, A, ...
    for (int i = 0; i < 12; i++) begin
      set_a(1, 1, 0, 12'($urandom), 16'($urandom));
      set_b(1, 1, 0, 12'($urandom), 16'($urandom));
      tick(xa, xb);
    end

    // A streams without last; bursts cut at BURST_MAX, B interleaves.
    drain();
    for (int i = 0; i < 24; i++) begin
      set_a(1, 0, 0, 12'($urandom), 16'($urandom));
      set_b(($urandom_range(1) == 1), 1, 0, 12'($urandom), 16'($urandom));
      tick(xa, xb);
    end

    // Known beat to bank 1 (display bank 0): addr 13F5, data 00ABCD.
    drain();
    a_beat(1, 0, 12'h3F5, 16'hABCD, 0);

    // frame_end without last: stall, vblank 5 cycles later, then resume.
    drain();
    a_beat(0, 1, 12'h010, 16'h1234, 0);
    for (int i = 0; i < 5; i++) begin
      set_a(1, 1, 0, 12'h011, 16'h5678);
      vblank = (i == 4);
      tick(xa, xb);
    end
    a_beat(1, 0, 12'h012, 16'h9ABC, 0);

    // frame_end coinciding with vblank: swap waits for the next vblank.
    drain();
    a_beat(1, 1, 12'h020, 16'h0F0F, 1);
    for (int i = 0; i < 4; i++) begin
      vblank = (i == 2);
      tick(xa, xb);
    end
    vblank = 0;

    // Reset in the middle of a B grant.
    drain();
    n = 0;
    xb = 0;
    while (!xb && n < 20) begin
      set_b(1, 0, 0, 12'($urandom), 16'($urandom));
      tick(xa, xb);
      n++;
    end
    chk("b_beat_timeout", xb, 1);
    set_b(1, 0, 0, 12'h0AA, 16'h5555);
    ctrl_resetn = 0;
    tick(xa, xb);
    ctrl_resetn = 1;
    set_b(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(xa, xb);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_a(($urandom_range(99) < 70), ($urandom_range(99) < 25), ($urandom_range(99) < 4),
            12'($urandom), 16'($urandom));
      set_b(($urandom_range(99) < 60), ($urandom_range(99) < 25), ($urandom_range(99) < 4),
            12'($urandom), 16'($urandom));
      vblank      = ($urandom_range(99) < 5);
      ctrl_resetn = ($urandom_range(999) != 0);
      tick(xa, xb);
    end

    ctrl_resetn = 1;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    vblank = 0;
    for (int i = 0; i < 3; i++) tick(xa, xb);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ledpanel_write_arbiter.md
LEDPANEL_WRITE_ARBITER -- requirements
Module: ledpanel_write_arbiter

Interface
REQ-001 Parameter: BURST_MAX, 64, maximum beats per grant before forced re-arbitration (1..256).
REQ-002 Parameter: PIX_AW, 12, pixel address width, {y[5:0], x[5:0]} for the 64x64 panel.
REQ-003 Port: ctrl_clk  in  1  single clock for the block; all logic on its rising edge.
REQ-004 Port: ctrl_resetn  in  1  synchronous, active-low reset.
REQ-005 Port: a_valid, a_last, a_frame_end  in  1 each  requester A (network pixel stream) beat qualifiers.
REQ-006 Port: a_addr  in  PIX_AW, and a_data  in  16  requester A pixel address and RGB565 data.
REQ-007 Port: a_ready  out  1  requester A beat accepted.
REQ-008 Port: b_valid, b_last, b_frame_end, b_addr, b_data, b_ready  requester B (pattern generator), same widths and directions as A.
REQ-009 Port: vblank  in  1  single-cycle pulse, already in ctrl_clk domain, marking display frame boundary.
REQ-010 Port: ctrl_en  out  1, ctrl_wr  out  4, ctrl_addr  out  16, ctrl_wdat  out  24  video-memory write port.
REQ-011 Port: disp_bank  out  1  bank the display reads; write bank is always !disp_bank.
REQ-012 Port: swap_pending  out  1  completed back-bank frame awaiting vblank.

Function
REQ-013 FSM states IDLE, GRANT_A, GRANT_B; exactly one state is active.
REQ-014 IDLE: a_valid -> GRANT_A; else b_valid -> GRANT_B; else stay. When both are valid, A wins unless last_grant==A, in which case B wins (round-robin).
REQ-015 Arbitration decision costs one cycle; first beat is accepted the cycle after leaving IDLE.
REQ-016 In GRANT_x: x_ready = 1 combinationally, except 0 while swap_pending==1; the other requester's ready = 0.
REQ-017 Beat transfer = x_valid && x_ready in the same cycle; transfers are counted in beat_cnt (width clog2(BURST_MAX)+1).
REQ-018 Grant ends (-> IDLE, last_grant = x) after a beat with x_last==1, or when beat_cnt reaches BURST_MAX; beat_cnt clears on exit.
REQ-019 x_valid deasserting mid-grant does not end the grant; the FSM holds until a last or limit beat.
REQ-020 Write output is registered, 1-cycle latency: ctrl_en=1, ctrl_wr=4'b0111, ctrl_addr={3'b000, !disp_bank, addr[11:0]}, ctrl_wdat={8'h00, data}; otherwise ctrl_en=0, ctrl_wr=0.
REQ-021 ctrl_addr/ctrl_wdat hold their last value when ctrl_en=0.
REQ-022 A transferred beat with frame_end==1 sets swap_pending, which blocks all further beats.
REQ-023 vblank with swap_pending==1: disp_bank toggles and swap_pending clears in the same edge; without swap_pending, vblank is ignored.
REQ-024 frame_end and vblank on the same cycle: swap_pending sets now; the swap waits for the next vblank.
REQ-025 frame_end without last: the grant is held with ready=0 until the swap completes, then resumes.

Reset
REQ-026 ctrl_resetn==0 at an edge: state=IDLE, last_grant=B, beat_cnt=0, disp_bank=0, swap_pending=0, ctrl_en=0, ctrl_wr=0, ctrl_addr=0, ctrl_wdat=0, a_ready=b_ready=0.
REQ-027 Reset mid-burst aborts the grant without emitting the pending write; no beat is accepted during reset.

Structure
REQ-028 Shared package ledpanel_pkg holds: the state enumeration, PIX_AW, RGB565 width (16), ctrl_wr write mask 4'b0111, and the bank bit position (12).
REQ-029 One sub-module, ledpanel_rr_pick: a 2-way round-robin pick (inputs a_valid, b_valid, last_grant; output winner). It is combinational; all sequential logic stays in the top.

Verification
REQ-030 After reset, a_valid=b_valid=1 -> GRANT_A is taken first; after a_last, GRANT_B; then alternating.
REQ-031 BURST_MAX=4, A streams 10 beats with no last -> grants of 4, 4, 2 beats, with B interleaved when valid.
REQ-032 A beat addr=12'h3F5, data=16'hABCD, disp_bank=0 -> next cycle ctrl_en=1, ctrl_addr=16'h13F5, ctrl_wdat=24'h00ABCD.
REQ-033 Beat with frame_end=1 -> swap_pending=1 and ready=0; vblank 5 cycles later -> disp_bank=1, swap_pending=0; the next write uses bank bit 0.
REQ-034 frame_end and vblank in the same cycle -> no toggle; the following vblank toggles disp_bank.
REQ-035 ctrl_resetn low mid-GRANT_B -> next cycle all outputs at reset values; ctrl_en never asserts for the aborted beat.
